// File: rtl/sd_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_block_sequencer_if
// Purpose  : Client, SD-mutex and SD-reader signal bundle of one block sequencer.
// Revision : 1.0
// ============================================================================
interface sd_block_sequencer_if #(
    parameter int COUNT_W = 16
);
    // Client side
    logic               i_start;
    logic [31:0]        i_start_block;
    logic [COUNT_W-1:0] i_block_count;
    logic               i_stop;
    logic               o_ready;
    logic               o_done;
    logic               o_error;
    logic [COUNT_W-1:0] o_blocks_done;

    // Mutex slot
    logic               o_request;
    logic               i_grant;

    // SD reader
    logic [31:0]        o_block;
    logic               o_read;
    logic               i_busy;
    logic               i_card_error;

    // Sequencer view
    modport master (
        input  i_start, i_start_block, i_block_count, i_stop,
        input  i_grant, i_busy, i_card_error,
        output o_ready, o_done, o_error, o_blocks_done,
        output o_request, o_block, o_read
    );

    // Client / mutex / reader view
    modport slave (
        output i_start, i_start_block, i_block_count, i_stop,
        output i_grant, i_busy, i_card_error,
        input  o_ready, o_done, o_error, o_blocks_done,
        input  o_request, o_block, o_read
    );
endinterface
`default_nettype wire

// File: rtl/sd_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_block_sequencer
// Purpose  : Acquires the SD mutex and issues one Read per consecutive block.
// Revision : 1.0
// ============================================================================
module sd_block_sequencer #(
    parameter int COUNT_W = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    sd_block_sequencer_if.master bus
);

    localparam int c_TMO_W = $clog2(TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_NEXT    = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_TMO_W-1:0] r_tmo;
    logic [31:0]        r_addr;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_blocks_done;
    logic               r_ready;
    logic               r_done;
    logic               r_error;
    logic               r_request;
    logic               r_read;
    logic [31:0]        r_block;

    logic               w_accept;
    logic               w_set_error;
    logic               w_block_ok;
    logic               w_tmo;
    logic               w_fault;
    logic               w_hold_mutex;

    // Card error and lost grant share the top priority once the mutex is held
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_set_error  = 1'b0;
        w_block_ok   = 1'b0;
        w_tmo        = (r_tmo == c_TMO_LAST);
        w_fault      = bus.i_card_error || !bus.i_grant;

        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = (bus.i_block_count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.i_card_error) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end else if (bus.i_stop) begin
                    w_state_next = S_RELEASE;
                end else if (bus.i_grant) begin
                    w_state_next = S_ISSUE;
                end else if (w_tmo) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end
            end
            S_ISSUE: begin
                if (w_fault) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end else if (bus.i_busy) begin
                    w_state_next = S_WAIT;
                end else if (w_tmo) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end
            end
            S_WAIT: begin
                if (w_fault) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end else if (!bus.i_busy) begin
                    w_block_ok   = 1'b1;
                    w_state_next = S_NEXT;
                end else if (w_tmo) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end
            end
            S_NEXT: begin
                if (w_fault) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_RELEASE;
                end else if ((r_blocks_done == r_count) || bus.i_stop) begin
                    w_state_next = S_RELEASE;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_RELEASE: w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_hold_mutex = (w_state_next == S_REQ)  || (w_state_next == S_ISSUE) ||
                       (w_state_next == S_WAIT) || (w_state_next == S_NEXT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo         <= '0;
            r_addr        <= '0;
            r_count       <= '0;
            r_blocks_done <= '0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_request     <= 1'b0;
            r_read        <= 1'b0;
            r_block       <= '0;
        end else begin
            r_tmo <= (w_state_next != r_state) ? '0 : r_tmo + c_TMO_W'(1);

            if (w_accept) begin
                r_addr        <= bus.i_start_block;
                r_count       <= bus.i_block_count;
                r_blocks_done <= '0;
            end else if (w_block_ok) begin
                r_addr        <= r_addr + 32'd1;
                r_blocks_done <= r_blocks_done + COUNT_W'(1);
            end

            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_set_error) begin
                r_error <= 1'b1;
            end

            r_ready   <= (w_state_next == S_IDLE);
            r_done    <= (w_state_next == S_DONE);
            r_request <= w_hold_mutex;
            r_read    <= (w_state_next == S_ISSUE);
            if (w_state_next == S_ISSUE) begin
                r_block <= r_addr;
            end
        end
    end

    assign bus.o_ready       = r_ready;
    assign bus.o_done        = r_done;
    assign bus.o_error       = r_error;
    assign bus.o_blocks_done = r_blocks_done;
    assign bus.o_request     = r_request;
    assign bus.o_read        = r_read;
    assign bus.o_block       = r_block;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_block_sequencer
// Purpose  : Self-checking bench with a mutex/reader responder and result model.
// Revision : 1.0
// ============================================================================
module tb_sd_block_sequencer;

    localparam int COUNT_W = 16;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    sd_block_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

    sd_block_sequencer #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sb;
        int          cnt;
        int          gdly;
        int          bdly;
        int          blen;
        int          stop_blk;
        int          cerr_blk;
        bit          no_grant;
        int          exp_reads;
        int          exp_bd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},   bus.o_ready,       1);
        check({tag, "_done"},    bus.o_done,        0);
        check({tag, "_error"},   bus.o_error,       0);
        check({tag, "_bdone"},   bus.o_blocks_done, 0);
        check({tag, "_request"}, bus.o_request,     0);
        check({tag, "_read"},    bus.o_read,        0);
        check({tag, "_block"},   bus.o_block,       0);
    endtask

    // Result of a sequence from its end cause: first of card error / Stop / count
    function automatic void model(input int cnt, input int stop_blk, input int cerr_blk,
                                  input bit no_grant, output int reads, output int bd,
                                  output bit err);
        int k_end;
        if (cnt == 0) begin
            reads = 0; bd = 0; err = 1'b0;
        end else if (no_grant) begin
            reads = 0; bd = 0; err = 1'b1;
        end else begin
            k_end = cnt;
            err   = 1'b0;
            if (stop_blk >= 1 && stop_blk < k_end) k_end = stop_blk;
            if (cerr_blk >= 1 && cerr_blk <= k_end) begin
                k_end = cerr_blk;
                err   = 1'b1;
            end
            reads = k_end;
            bd    = err ? k_end - 1 : k_end;
        end
    endfunction

    task automatic run_seq(input vec_t v);
        logic [31:0] addrs [$];
        logic [31:0] ea;
        int  cyc = 0, spans = 0, req_hi = 0, req_cnt = 0;
        int  phase = 0, rd_delay = 0, busy_age = 0, blk = 0;
        int  grant_cyc = -1, fall_cyc = -1, done_cyc = -1, gnt_lat = -1, lat_bad = 0;
        bit  prev_req = 1'b0, done_seen = 1'b0, g;

        bus.i_stop = 1'b0; bus.i_busy = 1'b0; bus.i_card_error = 1'b0; bus.i_grant = 1'b0;
        bus.i_start = 1'b1; bus.i_start_block = v.sb; bus.i_block_count = COUNT_W'(v.cnt);
        while (!done_seen && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                bus.i_start = 1'b0;
                bus.i_start_block = $urandom;
                bus.i_block_count = COUNT_W'($urandom);
                check("err_clr",  bus.o_error,   0);
                check("req_lat",  bus.o_request, v.cnt != 0);
                check("ready_lo", bus.o_ready,   0);
            end
            if (bus.o_request) req_hi++;
            if (bus.o_request && !prev_req) spans++;
            prev_req = bus.o_request;
            if (bus.o_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (bus.o_read && phase == 0) begin
                addrs.push_back(bus.o_block);
                if (addrs.size() == 1) gnt_lat = cyc - grant_cyc;
                else if (cyc - fall_cyc != 2) lat_bad++;
                phase    = 1;
                rd_delay = v.bdly;
            end
            // Mutex: grant once Request has been seen gdly+1 times
            if (bus.o_request) req_cnt++; else req_cnt = 0;
            g = !v.no_grant && bus.o_request && (req_cnt > v.gdly);
            if (g && grant_cyc < 0) grant_cyc = cyc;
            bus.i_grant = g;
            // Reader: Busy rises bdly cycles after Read, held blen cycles
            bus.i_card_error = 1'b0;
            if (phase == 2) begin
                busy_age++;
                if (busy_age == 1 && blk == v.cerr_blk) bus.i_card_error = 1'b1;
                if (busy_age >= v.blen) begin
                    bus.i_busy = 1'b0;
                    phase      = 0;
                    fall_cyc   = cyc;
                end
            end else if (phase == 1) begin
                if (rd_delay == 0) begin
                    bus.i_busy = 1'b1;
                    busy_age   = 0;
                    phase      = 2;
                    blk++;
                    if (blk == v.stop_blk) bus.i_stop = 1'b1;
                end else begin
                    rd_delay--;
                end
            end
        end
        bus.i_stop = 1'b0; bus.i_busy = 1'b0; bus.i_card_error = 1'b0; bus.i_grant = 1'b0;

        check("done_seen", done_seen, 1);
        check("reads", addrs.size(), v.exp_reads);
        for (int i = 0; i < addrs.size() && i < v.exp_reads; i++) begin
            ea = v.sb + 32'(i);
            check("block_addr", addrs[i], ea);
        end
        check("req_spans", spans, (v.cnt != 0) ? 1 : 0);
        if (v.exp_reads > 0) check("gnt2read", gnt_lat, 1);
        if (addrs.size() > 1) check("fall2read", lat_bad, 0);
        if (v.cnt != 0 && !v.exp_err) check("fall2done", done_cyc - fall_cyc, 3);
        if (v.no_grant && v.cnt != 0) check("tmo_len", req_hi, TIMEOUT);
        if (v.cnt == 0) check("zero_done", (done_cyc >= 1 && done_cyc <= 2), 1);
        @(posedge clk); #1;
        check("ready_back",  bus.o_ready,       1);
        check("done_pulse",  bus.o_done,        0);
        check("blocks_done", bus.o_blocks_done, v.exp_bd);
        check("error",       bus.o_error,       v.exp_err);
        check("req_off",     bus.o_request,     0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.i_start = 1'b0; bus.i_start_block = '0; bus.i_block_count = '0; bus.i_stop = 1'b0;
        bus.i_grant = 1'b0; bus.i_busy = 1'b0; bus.i_card_error = 1'b0;

        //          sb            cnt gd bd bl stp cer ng reads bd err
        vecs[0] = '{32'h0000_0100, 3, 2, 1, 10, 0,  0, 1'b0, 3, 3, 1'b0};
        vecs[1] = '{32'h0000_0200, 0, 0, 0, 2,  0,  0, 1'b0, 0, 0, 1'b0};
        vecs[2] = '{32'h0000_0300, 5, 1, 1, 6,  2,  0, 1'b0, 2, 2, 1'b0};
        vecs[3] = '{32'h0000_0400, 4, 1, 0, 5,  0,  2, 1'b0, 2, 1, 1'b1};
        vecs[4] = '{32'h0000_0500, 3, 0, 0, 2,  0,  0, 1'b1, 0, 0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 2, 0, 2, 3,  0,  0, 1'b0, 2, 2, 1'b0};
        vecs[6] = '{32'h0000_0010, 1, 0, 0, 2,  1,  0, 1'b0, 1, 1, 1'b0};
        vecs[7] = '{32'h0000_0020, 2, 3, 2, 4,  0,  1, 1'b0, 1, 0, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_seq(vecs[i]);

        // Reset in the middle of a block, with an ignored Start before it
        bus.i_start = 1'b1; bus.i_start_block = 32'hFFFF_FFFF; bus.i_block_count = 16'd3;
        @(posedge clk); #1;
        bus.i_start = 1'b0; bus.i_grant = 1'b1;
        for (int i = 0; i < 20 && !bus.o_read; i++) begin
            @(posedge clk); #1;
        end
        check("rs_read",  bus.o_read,  1);
        check("rs_block", bus.o_block, 32'hFFFF_FFFF);
        bus.i_busy = 1'b1;
        @(posedge clk); #1;
        check("rs_read_drop", bus.o_read, 0);
        bus.i_start = 1'b1; bus.i_block_count = '0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("start_ign_done", bus.o_done,    0);
        check("start_ign_req",  bus.o_request, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.i_busy = 1'b0; bus.i_grant = 1'b0;
        check_reset("rs");
        @(posedge clk); #1;

        for (int n = 0; n < 30; n++) begin
            v.sb       = $urandom;
            v.cnt      = $urandom_range(0, 6);
            v.gdly     = $urandom_range(0, 10);
            v.bdly     = $urandom_range(0, 5);
            v.blen     = $urandom_range(2, 12);
            v.stop_blk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            v.cerr_blk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            v.no_grant = ($urandom_range(0, 9) == 0);
            model(v.cnt, v.stop_blk, v.cerr_blk, v.no_grant, v.exp_reads, v.exp_bd, v.exp_err);
            run_seq(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
